// File: rtl/mmio_ports.sv
// mmio_ports: NPORTS-channel memory-mapped parallel I/O block on the dmem bus.
// Each channel has OUT (R/W), IN (RO, 2-flop synchronised), EDGE (sticky,
// write-1-to-clear) and IRQ_EN (R/W) at offsets 0x0/0x4/0x8/0xC of a 16-byte
// window. Reads are registered with one cycle of latency, like the dmem RAM.
// Build option MMIO_BOTH_EDGE_EN: when defined, EDGE flags capture every input
// transition instead of rising transitions only.
module mmio_ports #(
    parameter logic [31:0]      BASE      = 32'h1000_0000,
    parameter int               NPORTS    = 4,
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
    input  logic                     clk,
    input  logic                     reset_l,
    input  logic [31:0]              dmem_rd_addr,
    input  logic                     dmem_rd_req,
    output logic [31:0]              rd_data,
    output logic                     rd_ack,
    input  logic [31:0]              dmem_wr_addr,
    input  logic [31:0]              dmem_wr_data,
    input  logic [3:0]               dmem_wr_be,
    input  logic                     dmem_wr_req,
    input  logic [NPORTS*WIDTH-1:0]  inport,
    output logic [NPORTS*WIDTH-1:0]  outport,
    output logic                     irq
);

    localparam logic [31:0] SPAN = 32'(NPORTS * 16);

    typedef logic [NPORTS-1:0][WIDTH-1:0] bank_t;

    bank_t       out_q, out_d;
    bank_t       irq_en_q, irq_en_d;
    bank_t       edge_q, edge_d;
    bank_t       sync1_q, in_q, prev_q;
    bank_t       edge_set, edge_clr;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_ack_q, rd_ack_d;
    logic        irq_q, irq_d;

    logic [31:0]      rd_off, wr_off;
    logic             rd_hit, wr_hit;
    logic [3:0]       rd_chan, wr_chan;
    logic [1:0]       rd_reg, wr_reg;
    logic [31:0]      be_mask;
    logic [WIDTH-1:0] wr_mask, wr_val, rd_sel;

    // Address decode: the offset is only trusted once addr >= BASE, which
    // also keeps BASE + SPAN from wrapping near the top of the address space.
    assign rd_off  = dmem_rd_addr - BASE;
    assign rd_hit  = (dmem_rd_addr >= BASE) && (rd_off < SPAN);
    assign rd_chan = rd_off[7:4];
    assign rd_reg  = dmem_rd_addr[3:2];

    assign wr_off  = dmem_wr_addr - BASE;
    assign wr_hit  = dmem_wr_req && (dmem_wr_addr >= BASE) && (wr_off < SPAN);
    assign wr_chan = wr_off[7:4];
    assign wr_reg  = dmem_wr_addr[3:2];

    // Byte enables expand to a bit mask; lanes above WIDTH are simply dropped.
    assign be_mask = {{8{dmem_wr_be[3]}}, {8{dmem_wr_be[2]}},
                      {8{dmem_wr_be[1]}}, {8{dmem_wr_be[0]}}};
    assign wr_mask = be_mask[WIDTH-1:0];
    assign wr_val  = dmem_wr_data[WIDTH-1:0];

`ifdef MMIO_BOTH_EDGE_EN
    assign edge_set = in_q ^ prev_q;
`else
    assign edge_set = in_q & ~prev_q;
`endif

    // Register writes: OUT/IRQ_EN merge enabled bytes, EDGE takes W1C with set priority.
    always_comb begin
        out_d    = out_q;
        irq_en_d = irq_en_q;
        edge_clr = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (wr_hit && (wr_chan == 4'(k))) begin
                case (wr_reg)
                    2'd0:    out_d[k]    = (out_q[k] & ~wr_mask) | (wr_val & wr_mask);
                    2'd2:    edge_clr[k] = wr_val & wr_mask;
                    2'd3:    irq_en_d[k] = (irq_en_q[k] & ~wr_mask) | (wr_val & wr_mask);
                    default: ;
                endcase
            end
        end
        edge_d = (edge_q & ~edge_clr) | edge_set;
        irq_d  = |(edge_q & irq_en_q);
    end

    // Read mux: selects pre-write register contents and zero-extends to 32 bits.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (rd_chan == 4'(k)) begin
                case (rd_reg)
                    2'd0:    rd_sel = out_q[k];
                    2'd1:    rd_sel = in_q[k];
                    2'd2:    rd_sel = edge_q[k];
                    default: rd_sel = irq_en_q[k];
                endcase
            end
        end
        rd_ack_d  = dmem_rd_req && rd_hit;
        rd_data_d = '0;
        if (rd_ack_d) begin
            rd_data_d[WIDTH-1:0] = rd_sel;
        end
    end

    // State update, input synchroniser and registered outputs.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            out_q     <= {NPORTS{OUT_RESET}};
            irq_en_q  <= '0;
            edge_q    <= '0;
            sync1_q   <= '0;
            in_q      <= '0;
            prev_q    <= '0;
            rd_data_q <= '0;
            rd_ack_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            irq_en_q  <= irq_en_d;
            edge_q    <= edge_d;
            sync1_q   <= inport;
            in_q      <= sync1_q;
            prev_q    <= in_q;
            rd_data_q <= rd_data_d;
            rd_ack_q  <= rd_ack_d;
            irq_q     <= irq_d;
        end
    end

    assign outport = out_q;
    assign rd_data = rd_data_q;
    assign rd_ack  = rd_ack_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_mmio_ports.sv
// Directed bench for mmio_ports: a table of single-cycle bus operations with
// expected read responses, followed by hand-written multi-cycle sequences for
// read/write collision, input synchronisation, edge capture, W1C priority,
// interrupt latency and asynchronous reset.
module tb_mmio_ports;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam int          NPORTS = 4;
    localparam int          WIDTH  = 32;
    localparam logic [31:0] ORST   = 32'h0000_00A5;

    logic                    clk = 1'b0;
    logic                    reset_l;
    logic [31:0]             dmem_rd_addr;
    logic                    dmem_rd_req;
    logic [31:0]             rd_data;
    logic                    rd_ack;
    logic [31:0]             dmem_wr_addr;
    logic [31:0]             dmem_wr_data;
    logic [3:0]              dmem_wr_be;
    logic                    dmem_wr_req;
    logic [NPORTS*WIDTH-1:0] inport;
    logic [NPORTS*WIDTH-1:0] outport;
    logic                    irq;

    int total = 0;
    int bad   = 0;

    mmio_ports #(
        .BASE(BASE), .NPORTS(NPORTS), .WIDTH(WIDTH), .OUT_RESET(ORST)
    ) dut (
        .clk(clk), .reset_l(reset_l),
        .dmem_rd_addr(dmem_rd_addr), .dmem_rd_req(dmem_rd_req),
        .rd_data(rd_data), .rd_ack(rd_ack),
        .dmem_wr_addr(dmem_wr_addr), .dmem_wr_data(dmem_wr_data),
        .dmem_wr_be(dmem_wr_be), .dmem_wr_req(dmem_wr_req),
        .inport(inport), .outport(outport), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        ack;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        dmem_rd_req  = 1'b0;
        dmem_wr_req  = 1'b0;
        dmem_rd_addr = '0;
        dmem_wr_addr = '0;
        dmem_wr_data = '0;
        dmem_wr_be   = '0;
    endtask

    task automatic set_rd(input logic [31:0] a);
        dmem_rd_req  = 1'b1;
        dmem_rd_addr = a;
    endtask

    task automatic set_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        dmem_wr_req  = 1'b1;
        dmem_wr_addr = a;
        dmem_wr_data = d;
        dmem_wr_be   = be;
    endtask

    task automatic chk_outports(input string nm, input logic [31:0] c0, input logic [31:0] c1,
                                input logic [31:0] c2, input logic [31:0] c3);
        chk({nm, "_ch0"}, outport[31:0],   c0);
        chk({nm, "_ch1"}, outport[63:32],  c1);
        chk({nm, "_ch2"}, outport[95:64],  c2);
        chk({nm, "_ch3"}, outport[127:96], c3);
    endtask

    initial begin
        // {wr, addr, data, be, expected ack, expected rd_data}
        vecs[0]  = '{1'b0, BASE + 32'h00, 32'h0,         4'h0,    1'b1, 32'h0000_00A5};
        vecs[1]  = '{1'b1, BASE + 32'h10, 32'h1234_5678, 4'b0101, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, BASE + 32'h10, 32'h0,         4'h0,    1'b1, 32'h0034_0078};
        vecs[3]  = '{1'b0, BASE + 32'h00, 32'h0,         4'h0,    1'b1, 32'h0000_00A5};
        vecs[4]  = '{1'b0, BASE + 32'h20, 32'h0,         4'h0,    1'b1, 32'h0000_00A5};
        vecs[5]  = '{1'b0, BASE + 32'h30, 32'h0,         4'h0,    1'b1, 32'h0000_00A5};
        vecs[6]  = '{1'b1, BASE + 32'h14, 32'hFFFF_FFFF, 4'hF,    1'b0, 32'h0};
        vecs[7]  = '{1'b0, BASE + 32'h14, 32'h0,         4'h0,    1'b1, 32'h0};
        vecs[8]  = '{1'b1, BASE + 32'h0C, 32'hFFFF_0000, 4'b1100, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, BASE + 32'h0C, 32'h0,         4'h0,    1'b1, 32'hFFFF_0000};
        vecs[10] = '{1'b1, BASE + 32'h40, 32'hDEAD_BEEF, 4'hF,    1'b0, 32'h0};
        vecs[11] = '{1'b0, BASE + 32'h40, 32'h0,         4'h0,    1'b0, 32'h0};
        vecs[12] = '{1'b0, BASE + 32'h3C, 32'h0,         4'h0,    1'b1, 32'h0};
        vecs[13] = '{1'b0, BASE - 32'h4,  32'h0,         4'h0,    1'b0, 32'h0};
        vecs[14] = '{1'b0, BASE + 32'h03, 32'h0,         4'h0,    1'b1, 32'h0000_00A5};
        vecs[15] = '{1'b1, BASE + 32'h02, 32'h0000_00FF, 4'b0001, 1'b0, 32'h0};
        vecs[16] = '{1'b0, BASE + 32'h00, 32'h0,         4'h0,    1'b1, 32'h0000_00FF};

        idle_bus();
        inport  = '0;
        reset_l = 1'b0;
        tick();
        tick();
        chk("rst_ack",  {31'b0, rd_ack}, 32'h0);
        chk("rst_data", rd_data, 32'h0);
        chk("rst_irq",  {31'b0, irq}, 32'h0);
        chk_outports("rst_out", ORST, ORST, ORST, ORST);
        reset_l = 1'b1;
        tick();

        // Table of single-cycle bus operations.
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].wr) set_wr(vecs[i].addr, vecs[i].data, vecs[i].be);
            else            set_rd(vecs[i].addr);
            tick();
            idle_bus();
            chk($sformatf("vec%0d_ack", i),  {31'b0, rd_ack}, {31'b0, vecs[i].ack});
            chk($sformatf("vec%0d_data", i), rd_data, vecs[i].rdata);
        end
        chk_outports("tbl_out", 32'h0000_00FF, 32'h0034_0078, ORST, ORST);
        chk("tbl_irq", {31'b0, irq}, 32'h0);

        // Same-edge read and write of ch2 OUT: read sees old value, outport new.
        set_rd(BASE + 32'h20);
        set_wr(BASE + 32'h20, 32'h0000_0011, 4'hF);
        tick();
        idle_bus();
        chk("rw_same_data", rd_data, ORST);
        chk("rw_same_out",  outport[95:64], 32'h0000_0011);
        set_rd(BASE + 32'h20);
        tick();
        idle_bus();
        chk("rw_after", rd_data, 32'h0000_0011);

        // Enable IRQ on ch2 bit 3, then raise the input and track latency.
        set_wr(BASE + 32'h2C, 32'h0000_0008, 4'hF);
        tick();
        idle_bus();
        inport[67] = 1'b1;
        set_rd(BASE + 32'h24);
        tick();
        chk("in_e1", rd_data, 32'h0);
        tick();
        chk("in_e2", rd_data, 32'h0);
        set_rd(BASE + 32'h28);
        tick();
        chk("edge_e3", rd_data, 32'h0);
        chk("irq_e3", {31'b0, irq}, 32'h0);
        set_rd(BASE + 32'h24);
        tick();
        chk("in_e4", rd_data, 32'h8);
        chk("irq_e4", {31'b0, irq}, 32'h1);
        set_rd(BASE + 32'h28);
        tick();
        idle_bus();
        chk("edge_set", rd_data, 32'h8);

        // Drop and re-raise the input so a fresh rising edge meets a W1C.
        inport[67] = 1'b0;
        tick();
        tick();
        tick();
        inport[67] = 1'b1;
        tick();
        tick();
        set_wr(BASE + 32'h28, 32'h0000_0008, 4'hF);
        tick();
        idle_bus();
        set_rd(BASE + 32'h28);
        tick();
        idle_bus();
        chk("w1c_vs_set", rd_data, 32'h8);
        chk("w1c_vs_set_irq", {31'b0, irq}, 32'h1);

        // Plain W1C: EDGE clears on the write edge, irq one cycle later.
        set_wr(BASE + 32'h28, 32'h0000_0008, 4'hF);
        tick();
        idle_bus();
        chk("w1c_irq_lag", {31'b0, irq}, 32'h1);
        set_rd(BASE + 32'h28);
        tick();
        idle_bus();
        chk("w1c_edge", rd_data, 32'h0);
        chk("w1c_irq",  {31'b0, irq}, 32'h0);

        // Build up ch0 bit 16 edge/irq state, then reset with a read pending.
        inport[16] = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("ch0_irq", {31'b0, irq}, 32'h1);
        set_rd(BASE + 32'h08);
        tick();
        chk("ch0_edge_ack",  {31'b0, rd_ack}, 32'h1);
        chk("ch0_edge_data", rd_data, 32'h0001_0000);
        #3;
        reset_l = 1'b0;
        inport  = '0;
        #1;
        chk("arst_ack",  {31'b0, rd_ack}, 32'h0);
        chk("arst_data", rd_data, 32'h0);
        chk("arst_irq",  {31'b0, irq}, 32'h0);
        chk_outports("arst_out", ORST, ORST, ORST, ORST);
        tick();
        chk("arst_hold_ack", {31'b0, rd_ack}, 32'h0);
        idle_bus();
        reset_l = 1'b1;
        tick();
        chk("post_rst_ack", {31'b0, rd_ack}, 32'h0);
        set_rd(BASE + 32'h08);
        tick();
        chk("post_rst_edge", rd_data, 32'h0);
        set_rd(BASE + 32'h0C);
        tick();
        chk("post_rst_irqen", rd_data, 32'h0);
        set_rd(BASE + 32'h20);
        tick();
        idle_bus();
        chk("post_rst_out2", rd_data, ORST);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
